// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet iteration controller: state encoding,
// activation geometry and the self-excitation weight.
package maxnet_pkg;

    localparam int ACT_W    = 5;
    localparam int N_NEURON = 4;
    localparam int W_SELF   = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_MULT   = 3'd3;
    localparam logic [2:0] ST_ADD    = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        CHECK  = ST_CHECK,
        MULT   = ST_MULT,
        ADD    = ST_ADD,
        UPDATE = ST_UPDATE,
        DONE   = ST_DONE
    } state_t;

    // Negative two's-complement values collapse to zero.
    function automatic logic [ACT_W-1:0] relu(input logic [ACT_W-1:0] v);
        return v[ACT_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/pu.sv
// MaxNet processing unit: y = floor((w1*x1 - w2*x2 - w3*x3 - w4*x4) / 8),
// with a product register stage and a result register stage.
module pu
    import maxnet_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_mult,
    input  logic             en_cpa,
    input  logic [ACT_W-1:0] x1,
    input  logic [ACT_W-1:0] x2,
    input  logic [ACT_W-1:0] x3,
    input  logic [ACT_W-1:0] x4,
    input  logic [ACT_W-1:0] w1,
    input  logic [ACT_W-1:0] w2,
    input  logic [ACT_W-1:0] w3,
    input  logic [ACT_W-1:0] w4,
    output logic [ACT_W-1:0] y
);

    logic signed [9:0] xs1, xs2, xs3, xs4;
    logic signed [9:0] ws1, ws2, ws3, ws4;
    logic signed [9:0] p1, p2, p3, p4;
    logic signed [9:0] sum_q;

    assign xs1 = {{5{x1[4]}}, x1};
    assign xs2 = {{5{x2[4]}}, x2};
    assign xs3 = {{5{x3[4]}}, x3};
    assign xs4 = {{5{x4[4]}}, x4};
    assign ws1 = {{5{w1[4]}}, w1};
    assign ws2 = {{5{w2[4]}}, w2};
    assign ws3 = {{5{w3[4]}}, w3};
    assign ws4 = {{5{w4[4]}}, w4};

    always_ff @(posedge clk) begin
        if (rst) begin
            p1    <= '0;
            p2    <= '0;
            p3    <= '0;
            p4    <= '0;
            sum_q <= '0;
        end else begin
            if (en_mult) begin
                p1 <= xs1 * ws1;
                p2 <= xs2 * ws2;
                p3 <= xs3 * ws3;
                p4 <= xs4 * ws4;
            end
            if (en_cpa) begin
                sum_q <= p1 - p2 - p3 - p4;
            end
        end
    end

    // Arithmetic shift gives floor division by the weight scale of 8.
    assign y = 5'(sum_q >>> 3);

endmodule

// File: rtl/winner_detect.sv
// Counts nonzero activations and finds the lowest-index nonzero one
// (index 0 when all are zero).
module winner_detect
    import maxnet_pkg::*;
(
    input  logic [ACT_W-1:0] a1,
    input  logic [ACT_W-1:0] a2,
    input  logic [ACT_W-1:0] a3,
    input  logic [ACT_W-1:0] a4,
    output logic [2:0]       count,
    output logic [1:0]       index
);

    always_comb begin
        count = {2'b00, |a1} + {2'b00, |a2} + {2'b00, |a3} + {2'b00, |a4};
        index = 2'd0;
        if (|a4) index = 2'd3;
        if (|a3) index = 2'd2;
        if (|a2) index = 2'd1;
        if (|a1) index = 2'd0;
    end

endmodule

// File: rtl/maxnet_ctrl.sv
// Iteration controller for a 4-neuron MaxNet: loads activations, sequences
// the external PUs, applies ReLU write-back and reports the surviving neuron.
module maxnet_ctrl
    import maxnet_pkg::*;
#(
    parameter int W_INH    = 2,
    parameter int MAX_ITER = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACT_W-1:0] x_in1,
    input  logic [ACT_W-1:0] x_in2,
    input  logic [ACT_W-1:0] x_in3,
    input  logic [ACT_W-1:0] x_in4,
    input  logic [ACT_W-1:0] pu_out1,
    input  logic [ACT_W-1:0] pu_out2,
    input  logic [ACT_W-1:0] pu_out3,
    input  logic [ACT_W-1:0] pu_out4,
    output logic [ACT_W-1:0] act1,
    output logic [ACT_W-1:0] act2,
    output logic [ACT_W-1:0] act3,
    output logic [ACT_W-1:0] act4,
    output logic [ACT_W-1:0] w_self,
    output logic [ACT_W-1:0] w_inh,
    output logic             pen_mult,
    output logic             pen_cpa,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner,
    output logic             winner_valid,
    output logic [3:0]       iter_count
);

    state_t     state;
    logic [3:0] iter;
    logic [2:0] nz_count;
    logic [1:0] nz_index;

    winner_detect u_detect (
        .a1    (act1),
        .a2    (act2),
        .a3    (act3),
        .a4    (act4),
        .count (nz_count),
        .index (nz_index)
    );

    assign w_self   = 5'(W_SELF);
    assign w_inh    = 5'(W_INH);
    assign pen_mult = (state == MULT);
    assign pen_cpa  = (state == ADD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Results are latched on the way into DONE so they are already valid
    // during the done pulse; activations do not change between the two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            act1         <= '0;
            act2         <= '0;
            act3         <= '0;
            act4         <= '0;
            iter         <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            iter_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    act1  <= x_in1[4] ? '0 : {1'b0, x_in1[3:0]};
                    act2  <= x_in2[4] ? '0 : {1'b0, x_in2[3:0]};
                    act3  <= x_in3[4] ? '0 : {1'b0, x_in3[3:0]};
                    act4  <= x_in4[4] ? '0 : {1'b0, x_in4[3:0]};
                    iter  <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (nz_count <= 3'd1 || iter == 4'(MAX_ITER)) begin
                        winner       <= nz_index;
                        winner_valid <= (nz_count == 3'd1);
                        iter_count   <= iter;
                        state        <= DONE;
                    end else begin
                        state <= MULT;
                    end
                end
                MULT: state <= ADD;
                ADD:  state <= UPDATE;
                UPDATE: begin
                    act1  <= relu(pu_out1);
                    act2  <= relu(pu_out2);
                    act3  <= relu(pu_out3);
                    act4  <= relu(pu_out4);
                    iter  <= iter + 4'd1;
                    state <= CHECK;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Closed-loop bench: two controller+PU systems (W_INH=2/cap 15 and
// W_INH=1/cap 3) driven with the same inputs and checked against an
// arithmetic MaxNet model.
module tb_maxnet_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] x_in [4];

    logic [4:0] act    [2][4];
    logic [4:0] pu_out [2][4];
    logic [4:0] w_self [2];
    logic [4:0] w_inh  [2];
    logic       pen_mult [2];
    logic       pen_cpa  [2];
    logic       busy     [2];
    logic       done     [2];
    logic [1:0] winner   [2];
    logic       winner_valid [2];
    logic [3:0] iter_count   [2];

    int w_param   [2] = '{2, 1};
    int cap_param [2] = '{15, 3};

    int m_act [2][16][4];
    int m_iter   [2];
    int m_winner [2];
    int m_valid  [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_sys
        localparam int WI = (g == 0) ? 2 : 1;
        localparam int MI = (g == 0) ? 15 : 3;

        maxnet_ctrl #(.W_INH(WI), .MAX_ITER(MI)) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .x_in1        (x_in[0]),
            .x_in2        (x_in[1]),
            .x_in3        (x_in[2]),
            .x_in4        (x_in[3]),
            .pu_out1      (pu_out[g][0]),
            .pu_out2      (pu_out[g][1]),
            .pu_out3      (pu_out[g][2]),
            .pu_out4      (pu_out[g][3]),
            .act1         (act[g][0]),
            .act2         (act[g][1]),
            .act3         (act[g][2]),
            .act4         (act[g][3]),
            .w_self       (w_self[g]),
            .w_inh        (w_inh[g]),
            .pen_mult     (pen_mult[g]),
            .pen_cpa      (pen_cpa[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .winner       (winner[g]),
            .winner_valid (winner_valid[g]),
            .iter_count   (iter_count[g])
        );

        pu pu1 (.clk(clk), .rst(rst), .en_mult(pen_mult[g]), .en_cpa(pen_cpa[g]),
                .x1(act[g][0]), .x2(act[g][1]), .x3(act[g][2]), .x4(act[g][3]),
                .w1(w_self[g]), .w2(w_inh[g]), .w3(w_inh[g]), .w4(w_inh[g]),
                .y(pu_out[g][0]));
        pu pu2 (.clk(clk), .rst(rst), .en_mult(pen_mult[g]), .en_cpa(pen_cpa[g]),
                .x1(act[g][1]), .x2(act[g][0]), .x3(act[g][2]), .x4(act[g][3]),
                .w1(w_self[g]), .w2(w_inh[g]), .w3(w_inh[g]), .w4(w_inh[g]),
                .y(pu_out[g][1]));
        pu pu3 (.clk(clk), .rst(rst), .en_mult(pen_mult[g]), .en_cpa(pen_cpa[g]),
                .x1(act[g][2]), .x2(act[g][0]), .x3(act[g][1]), .x4(act[g][3]),
                .w1(w_self[g]), .w2(w_inh[g]), .w3(w_inh[g]), .w4(w_inh[g]),
                .y(pu_out[g][2]));
        pu pu4 (.clk(clk), .rst(rst), .en_mult(pen_mult[g]), .en_cpa(pen_cpa[g]),
                .x1(act[g][3]), .x2(act[g][0]), .x3(act[g][1]), .x4(act[g][2]),
                .w1(w_self[g]), .w2(w_inh[g]), .w3(w_inh[g]), .w4(w_inh[g]),
                .y(pu_out[g][3]));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // MaxNet iteration in plain integer arithmetic: a_k' = max(0, floor(a_k - eps*sum(others))).
    function automatic void runModel(input int g);
        int a [4];
        int nv [4];
        int cnt, total, n;
        for (int k = 0; k < 4; k++) a[k] = x_in[k][4] ? 0 : int'(x_in[k][3:0]);
        n = 0;
        for (int k = 0; k < 4; k++) m_act[g][0][k] = a[k];
        cnt = 0;
        for (int k = 0; k < 4; k++) if (a[k] != 0) cnt++;
        while (cnt > 1 && n < cap_param[g]) begin
            total = a[0] + a[1] + a[2] + a[3];
            for (int k = 0; k < 4; k++) nv[k] = 8 * a[k] - w_param[g] * (total - a[k]);
            for (int k = 0; k < 4; k++) a[k] = (nv[k] < 0) ? 0 : nv[k] / 8;
            n++;
            for (int k = 0; k < 4; k++) m_act[g][n][k] = a[k];
            cnt = 0;
            for (int k = 0; k < 4; k++) if (a[k] != 0) cnt++;
        end
        m_iter[g]   = n;
        m_valid[g]  = (cnt == 1) ? 1 : 0;
        m_winner[g] = 0;
        for (int k = 3; k >= 0; k--) if (a[k] != 0) m_winner[g] = k;
    endfunction

    // One complete run on both systems; glitch_cycle > 0 pulses start once mid-run.
    task automatic applyStimulus(input logic [4:0] x0, input logic [4:0] x1,
                                 input logic [4:0] x2, input logic [4:0] x3,
                                 input int glitch_cycle);
        int done_cyc [2];
        int n_mult [2], n_cpa [2], n_both [2], n_busy [2], n_done [2];
        int last_cyc;
        @(negedge clk);
        x_in[0] = x0; x_in[1] = x1; x_in[2] = x2; x_in[3] = x3;
        start = 1'b1;
        runModel(0);
        runModel(1);
        last_cyc = 4 * ((m_iter[0] > m_iter[1]) ? m_iter[0] : m_iter[1]) + 5;
        for (int g = 0; g < 2; g++) begin
            done_cyc[g] = -1;
            n_mult[g] = 0; n_cpa[g] = 0; n_both[g] = 0; n_busy[g] = 0; n_done[g] = 0;
        end
        for (int c = 1; c <= last_cyc; c++) begin
            @(negedge clk);
            start = (c == glitch_cycle) ? 1'b1 : 1'b0;
            for (int g = 0; g < 2; g++) begin
                if (pen_mult[g]) n_mult[g]++;
                if (pen_cpa[g]) n_cpa[g]++;
                if (pen_mult[g] && pen_cpa[g]) n_both[g]++;
                if (busy[g]) n_busy[g]++;
                if (done[g]) begin
                    n_done[g]++;
                    if (done_cyc[g] < 0) done_cyc[g] = c;
                end
                if (c >= 2 && (c - 2) % 4 == 0 && (c - 2) / 4 <= m_iter[g]) begin
                    for (int k = 0; k < 4; k++)
                        checkOutput($sformatf("sys%0d act%0d iter%0d", g, k + 1, (c - 2) / 4),
                                    32'(act[g][k]), 32'(m_act[g][(c - 2) / 4][k]));
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("sys%0d done_cycle", g), 32'(done_cyc[g]), 32'(4 * m_iter[g] + 3));
            checkOutput($sformatf("sys%0d done_pulses", g), 32'(n_done[g]), 32'd1);
            checkOutput($sformatf("sys%0d pen_mult_pulses", g), 32'(n_mult[g]), 32'(m_iter[g]));
            checkOutput($sformatf("sys%0d pen_cpa_pulses", g), 32'(n_cpa[g]), 32'(m_iter[g]));
            checkOutput($sformatf("sys%0d pen_overlap", g), 32'(n_both[g]), 32'd0);
            checkOutput($sformatf("sys%0d busy_cycles", g), 32'(n_busy[g]), 32'(4 * m_iter[g] + 3));
            checkOutput($sformatf("sys%0d winner", g), 32'(winner[g]), 32'(m_winner[g]));
            checkOutput($sformatf("sys%0d winner_valid", g), 32'(winner_valid[g]), 32'(m_valid[g]));
            checkOutput($sformatf("sys%0d iter_count", g), 32'(iter_count[g]), 32'(m_iter[g]));
        end
    endtask

    initial begin
        int quiet_errs;
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) x_in[k] = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("sys%0d reset busy", g), 32'(busy[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset done", g), 32'(done[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset pen_mult", g), 32'(pen_mult[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset pen_cpa", g), 32'(pen_cpa[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset winner", g), 32'(winner[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset winner_valid", g), 32'(winner_valid[g]), 32'd0);
            checkOutput($sformatf("sys%0d reset iter_count", g), 32'(iter_count[g]), 32'd0);
            for (int k = 0; k < 4; k++)
                checkOutput($sformatf("sys%0d reset act%0d", g, k + 1), 32'(act[g][k]), 32'd0);
            checkOutput($sformatf("sys%0d w_self", g), 32'(w_self[g]), 32'd8);
            checkOutput($sformatf("sys%0d w_inh", g), 32'(w_inh[g]), 32'(w_param[g]));
        end
        rst = 1'b0;
        @(negedge clk);

        // Reference pattern, plus direct spot checks on the W_INH=2 system.
        applyStimulus(5'd8, 5'd4, 5'd2, 5'd1, 0);
        checkOutput("ref final act1", 32'(act[0][0]), 32'd5);
        checkOutput("ref final act2", 32'(act[0][1]), 32'd0);
        checkOutput("ref iter_count", 32'(iter_count[0]), 32'd2);
        checkOutput("ref winner_valid", 32'(winner_valid[0]), 32'd1);

        // Single nonzero input: no iterations.
        applyStimulus(5'd0, 5'd0, 5'd7, 5'd0, 0);
        checkOutput("single winner", 32'(winner[0]), 32'd2);
        checkOutput("single iter_count", 32'(iter_count[0]), 32'd0);

        // Tie decays to all zero.
        applyStimulus(5'd5, 5'd5, 5'd0, 5'd0, 0);
        checkOutput("tie winner_valid", 32'(winner_valid[0]), 32'd0);
        checkOutput("tie winner", 32'(winner[0]), 32'd0);

        // Negative input clamps to zero on load.
        applyStimulus(5'h13, 5'd2, 5'd0, 5'd0, 0);
        checkOutput("neg winner", 32'(winner[0]), 32'd1);

        // Start pulsed while busy must not disturb the run.
        applyStimulus(5'd8, 5'd4, 5'd2, 5'd1, 5);

        // All zero inputs.
        applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 0);

        // Reset during ADD of iteration 1.
        @(negedge clk);
        x_in[0] = 5'd8; x_in[1] = 5'd4; x_in[2] = 5'd2; x_in[3] = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            checkOutput($sformatf("sys%0d pre-reset pen_cpa", g), 32'(pen_cpa[g]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("sys%0d abort busy", g), 32'(busy[g]), 32'd0);
            checkOutput($sformatf("sys%0d abort pen_cpa", g), 32'(pen_cpa[g]), 32'd0);
            checkOutput($sformatf("sys%0d abort done", g), 32'(done[g]), 32'd0);
            checkOutput($sformatf("sys%0d abort iter_count", g), 32'(iter_count[g]), 32'd0);
            checkOutput($sformatf("sys%0d abort winner_valid", g), 32'(winner_valid[g]), 32'd0);
            for (int k = 0; k < 4; k++)
                checkOutput($sformatf("sys%0d abort act%0d", g, k + 1), 32'(act[g][k]), 32'd0);
        end
        rst = 1'b0;
        quiet_errs = 0;
        repeat (12) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++)
                if (pen_mult[g] || pen_cpa[g] || busy[g] || done[g]) quiet_errs++;
        end
        checkOutput("post-abort quiet", 32'(quiet_errs), 32'd0);

        // Randomized activations.
        for (int r = 0; r < 24; r++) begin
            applyStimulus(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/maxnet_ctrl.md
# maxnet_ctrl

Iteration controller for the 4-neuron MaxNet built from four `pu` instances. It loads four input activations and drives the PU operand buses and the PU register enables (`pen_mult`, `pen_cpa`). Each iteration it captures the four 5-bit PU outputs, applies ReLU and writes them back as the new activations. It repeats until at most one activation is nonzero or an iteration cap is reached, then reports the winner.

## Interface
- `W_INH`, default 2: inhibition weight magnitude (ε = W_INH/8). Legal range 1..2, which keeps PU results within 8-bit signed.
- `MAX_ITER`, default 15: iteration cap, 1..15.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sampled only in IDLE; begins a run.
- `x_in1..x_in4` in 5 each: initial activations. Bit 4 is the sign, bits 3:0 the magnitude.
- `pu_out1..pu_out4` in 5 each: outputs of PU1..PU4, read as 5-bit two's complement.
- `act1..act4` out 5 each: current activations. Bit 4 is always 0.
- `w_self` out 5: constant 5'd8 (weight 1.0).
- `w_inh` out 5: constant W_INH.
- `pen_mult` out 1: PU multiplier-register enable.
- `pen_cpa` out 1: PU result-register enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `winner` out 2: index (0..3) of the surviving neuron.
- `winner_valid` out 1: 1 if exactly one activation is nonzero at the end of the run.
- `iter_count` out 4: number of iterations executed in the last run.

## Operation
- Top-level wiring, fixed:
  - PU k receives x1 = act_k and x2..x4 = the other three activations in ascending index order.
  - w1 = `w_self`; w2..w4 = `w_inh`.
- FSM states: IDLE, LOAD, CHECK, MULT, ADD, UPDATE, DONE.
- IDLE: when `start`=1, go to LOAD.
- LOAD:
  - `act_k` ← {1'b0, x_in_k[3:0]}; if x_in_k[4]=1, `act_k` ← 0 (negative inputs clamp to zero).
  - Clear the iteration counter; go to CHECK.
- CHECK: count the nonzero `act_k`.
  - If count ≤ 1 or iter = MAX_ITER, go to DONE.
  - Otherwise go to MULT.
- MULT: `pen_mult`=1 for this cycle only; go to ADD.
- ADD: `pen_cpa`=1 for this cycle only; go to UPDATE.
- UPDATE:
  - `act_k` ← (pu_out_k[4] ? 0 : pu_out_k). All four update in the same cycle.
  - iter ← iter+1; go to CHECK.
- DONE:
  - `done`=1 for one cycle.
  - `winner` = lowest index with nonzero activation, or 0 if all activations are zero.
  - `winner_valid` = (nonzero count == 1).
  - `iter_count` = iter.
  - Go to IDLE.
- `winner`, `winner_valid` and `iter_count` hold their values until the next DONE.
- Activations stay unchanged in IDLE. `start` is ignored while `busy`=1.
- Ties:
  - Equal maxima may all reach 0 together. The run then ends with `winner_valid`=0 and `winner`=0.
  - If the cap is hit with ≥2 nonzero activations, `winner_valid`=0.

## Timing
- Reset values: state IDLE; `act1..act4`, `pen_mult`, `pen_cpa`, `busy`, `done`, `winner`, `winner_valid`, `iter_count` and the internal iter are all 0.
- Reset taken in any state aborts the run on the next edge.
- Taking `start`=1 in cycle 0: LOAD is cycle 1 and CHECK is cycle 2.
- Each iteration is 4 cycles (MULT, ADD, UPDATE, CHECK).
- For N iterations, `done` is high in cycle 4N+3; N=0 gives cycle 3.
- `pen_mult` is high only in MULT and `pen_cpa` only in ADD. They are never high together and never outside a run.
- `pu_out_k` is sampled only in UPDATE, one cycle after `pen_cpa`. This gives the PU's combinational adders a full cycle to settle after `pen_mult`.
- Outputs are Moore: `pen_mult`, `pen_cpa`, `busy` and `done` decode from the registered state.

## Structure
- Package `maxnet_pkg`:
  - state encoding (3-bit localparams);
  - `W_SELF` = 8, activation width 5, neuron count 4.
- Sub-module `winner_detect`:
  - combinational;
  - inputs: four 5-bit activations;
  - outputs: 3-bit nonzero count and 2-bit lowest nonzero index.
  - It is shared by CHECK and DONE.
- The bench instantiates `maxnet_ctrl` together with four `pu` instances for closed-loop tests.

## Test plan
- Reset, then `start` with x_in=(8,4,2,1) and W_INH=2, closed loop with PUs:
  - after iteration 1, act=(6,1,0,0); after iteration 2, act=(5,0,0,0);
  - `done` in cycle 11, `winner`=0, `winner_valid`=1, `iter_count`=2.
- x_in=(0,0,7,0): `done` in cycle 3, `winner`=2, `winner_valid`=1, `iter_count`=0, `pen_mult` never asserted.
- x_in=(5,5,0,0) → ends with all zero or with the cap reached; `winner_valid`=0, and `iter_count` ≤ 15.
- Negative inputs x_in=(5'h13,2,0,0) → act1 loads 0; ends with `winner`=1 and `iter_count`=0.
- `rst` asserted during ADD of iteration 1 → next cycle state is IDLE, all outputs 0, no further `pen_*` pulses.
- `start` pulsed while `busy` → ignored: the cycle count to `done` and the final results are unchanged.
